pci_io_arbiter: RTL

Owns the PCI IO-window register file and shares it between the PCI target (host side) and up to NUM_REQ local consumers (step generators, GPIO, status logic). PCI accesses have absolute priority and are always served in one cycle, so the target's zero-wait-state TRDY behaviour holds. Local requesters are served round-robin through a req/grant handshake. Per-word dirty flags tell consumers which command words the host has rewritten since they last read them.

---
 rtl/pci_io_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/pci_io_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/pci_io_pkg.sv
// Shared constants for the PCI IO-window register file and its arbiter.
// Word map, default sizing and local requester IDs.
package pci_io_pkg;

  localparam int NUM_REQ_DEF   = 4;
  localparam int ADDR_BITS_DEF = 2;

  typedef enum logic [1:0] {
    W_CMD        = 2'd0,
    W_STATUS     = 2'd1,
    W_STEP_RATE  = 2'd2,
    W_STEP_COUNT = 2'd3
  } word_e;

  localparam int REQ_STEP0  = 0;
  localparam int REQ_STEP1  = 1;
  localparam int REQ_GPIO   = 2;
  localparam int REQ_STATUS = 3;

  function automatic int ptr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or above ptr, wrapping.
// Purely combinational, one-hot result.
module rr_arbiter
  import pci_io_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  localparam int PW = ptr_bits(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PW'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pci_io_arbiter.sv
// PCI IO-window register file: PCI target has absolute priority,
// local consumers share the remaining cycles round-robin.
module pci_io_arbiter
  import pci_io_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  localparam int DEPTH = 2 ** ADDR_BITS,
  localparam int PW    = ptr_bits(NUM_REQ)
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          PCI_REQ,
  input  logic                          PCI_WE,
  input  logic [ADDR_BITS-1:0]          PCI_ADDR,
  input  logic [31:0]                   PCI_WDATA,
  input  logic [3:0]                    PCI_BE_N,
  output logic [31:0]                   PCI_RDATA,
  output logic                          PCI_ACK,
  input  logic [NUM_REQ-1:0]            LREQ,
  input  logic [NUM_REQ-1:0]            LWE,
  input  logic [NUM_REQ*ADDR_BITS-1:0]  LADDR,
  input  logic [NUM_REQ*32-1:0]         LWDATA,
  output logic [NUM_REQ-1:0]            LGNT,
  output logic [31:0]                   LRDATA,
  output logic [DEPTH-1:0]              DIRTY,
  output logic                          WR_EVENT,
  output logic                          PING_DONE
);

  logic [31:0]          mem [DEPTH];
  logic [PW-1:0]        rr_ptr;
  logic [NUM_REQ-1:0]   gnt;
  logic [PW-1:0]        win;
  logic [ADDR_BITS-1:0] l_addr;
  logic [31:0]          l_wdata;
  logic                 l_we;
  logic [PW-1:0]        nxt_ptr;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req (LREQ),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  always_comb begin
    win     = '0;
    l_addr  = '0;
    l_wdata = '0;
    l_we    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        win     = PW'(i);
        l_addr  = LADDR[i*ADDR_BITS +: ADDR_BITS];
        l_wdata = LWDATA[i*32 +: 32];
        l_we    = LWE[i];
      end
    end
    nxt_ptr = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rr_ptr    <= '0;
      DIRTY     <= '0;
      PCI_ACK   <= 1'b0;
      PCI_RDATA <= '0;
      LGNT      <= '0;
      LRDATA    <= '0;
      WR_EVENT  <= 1'b0;
      PING_DONE <= 1'b0;
    end else begin
      PCI_ACK  <= 1'b0;
      LGNT     <= '0;
      WR_EVENT <= 1'b0;
      if (PCI_REQ) begin
        PCI_ACK <= 1'b1;
        if (PCI_WE) begin
          for (int k = 0; k < 4; k++) begin
            if (!PCI_BE_N[k])
              mem[PCI_ADDR][8*k +: 8] <= PCI_WDATA[8*k +: 8];
          end
          DIRTY[PCI_ADDR] <= 1'b1;
          WR_EVENT        <= 1'b1;
          PING_DONE       <= 1'b1;
        end else begin
          PCI_RDATA <= mem[PCI_ADDR];
        end
      end else if (|LREQ) begin
        LGNT   <= gnt;
        LRDATA <= mem[l_addr];
        rr_ptr <= nxt_ptr;
        // a consumer read acknowledges the host's latest write
        if (l_we) mem[l_addr] <= l_wdata;
        else      DIRTY[l_addr] <= 1'b0;
      end
    end
  end

endmodule
